// File: rtl/booth_controller.sv
// Moore control FSM for a 4-iteration Booth multiplier datapath.
// Issues load/clear, add/subtract and shift strobes; iteration count comes from the external shift counter.
module booth_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q0,
  input  logic       qm1,
  input  logic       seen4,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       ld_m,
  output logic       ld_q,
  output logic       clr_a,
  output logic       clr_qm1,
  output logic       ld_a,
  output logic       sub,
  output logic       shift,
  output logic       clrc,
  output logic       count_up,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ADD   = 3'd3,
    ST_SUB   = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and Moore output decode; unused encoding 3'd7 falls back to IDLE.
  always_comb begin
    w_next   = ST_IDLE;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    ld_m     = 1'b0;
    ld_q     = 1'b0;
    clr_a    = 1'b0;
    clr_qm1  = 1'b0;
    ld_a     = 1'b0;
    sub      = 1'b0;
    shift    = 1'b0;
    clrc     = 1'b0;
    count_up = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready  = 1'b1;
        w_next = start ? ST_INIT : ST_IDLE;
      end
      ST_INIT: begin
        busy    = 1'b1;
        ld_m    = 1'b1;
        ld_q    = 1'b1;
        clr_a   = 1'b1;
        clr_qm1 = 1'b1;
        clrc    = 1'b1;
        w_next  = ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (seen4)                   w_next = ST_DONE;
        else if ({q0, qm1} == 2'b10) w_next = ST_SUB;
        else if ({q0, qm1} == 2'b01) w_next = ST_ADD;
        else                         w_next = ST_SHIFT;
      end
      ST_ADD: begin
        busy   = 1'b1;
        ld_a   = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SUB: begin
        busy   = 1'b1;
        ld_a   = 1'b1;
        sub    = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        shift    = 1'b1;
        count_up = 1'b1;
        w_next   = ST_CHECK;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller: models the shift counter and the Q/Q-1 bits of the datapath.
module tb_booth_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       q0, qm1, seen4;
  logic       ready, busy, done, ld_m, ld_q, clr_a, clr_qm1;
  logic       ld_a, sub, shift, clrc, count_up;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Handshake: start is a level request sampled by the DUT only while ready is high.
  booth_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .qm1(qm1), .seen4(seen4),
    .ready(ready), .busy(busy), .done(done), .ld_m(ld_m), .ld_q(ld_q),
    .clr_a(clr_a), .clr_qm1(clr_qm1), .ld_a(ld_a), .sub(sub), .shift(shift),
    .clrc(clrc), .count_up(count_up), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Shift counter and multiplier bit model.
  logic [2:0] cnt = 3'd0;
  logic [7:0] mult = 8'd0;
  logic       force_s4 = 1'b0;

  always @(posedge clk) begin
    if (clrc)          cnt <= 3'd0;
    else if (count_up) cnt <= cnt + 3'd1;
  end

  always_comb begin
    q0    = mult[cnt];
    qm1   = (cnt == 3'd0) ? 1'b0 : mult[cnt - 3'd1];
    seen4 = force_s4 | (cnt == 3'd4);
  end

  wire [11:0] outs = {ready, busy, done, ld_m, ld_q, clr_a, clr_qm1, ld_a, sub, shift, clrc, count_up};

  localparam logic [11:0] O_IDLE  = 12'b1000_0000_0000;
  localparam logic [11:0] O_INIT  = 12'b0101_1110_0010;
  localparam logic [11:0] O_CHECK = 12'b0100_0000_0000;
  localparam logic [11:0] O_ADD   = 12'b0100_0001_0000;
  localparam logic [11:0] O_SUB   = 12'b0100_0001_1000;
  localparam logic [11:0] O_SHIFT = 12'b0100_0000_0101;
  localparam logic [11:0] O_DONE  = 12'b0010_0000_0000;

  logic [11:0] tr  [0:31];
  logic [11:0] exp_v [0:31];

  // Pulse start at the next edge and record the outputs of cycles 1..ncyc (cycle 1 = INIT).
  task automatic trace_run(input int ncyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      tr[c] = outs;
      if (c < ncyc) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs !== O_IDLE || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_async: outs=%b state=%0d expected outs=%b state=0", outs, dbg_state, O_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (outs !== O_IDLE) begin
      n_err++;
      $display("FAIL reset_release: outs=%b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_mult0;
    int n_cu, n_lda;
    mult = 8'd0;
    trace_run(12);
    exp_v[1] = O_INIT;
    for (int i = 0; i < 4; i++) begin
      exp_v[2 + 2 * i] = O_CHECK;
      exp_v[3 + 2 * i] = O_SHIFT;
    end
    exp_v[10] = O_CHECK;
    exp_v[11] = O_DONE;
    exp_v[12] = O_IDLE;
    n_cu = 0;
    n_lda = 0;
    for (int c = 1; c <= 12; c++) begin
      n_vec++;
      if (tr[c] !== exp_v[c]) begin
        n_err++;
        $display("FAIL mult0 cyc%0d: outs=%b expected %b", c, tr[c], exp_v[c]);
      end
      if (tr[c][0] === 1'b1) n_cu++;
      if (tr[c][4] === 1'b1) n_lda++;
    end
    n_vec++;
    if (n_cu != 4 || n_lda != 0) begin
      n_err++;
      $display("FAIL mult0 counts: count_up=%0d ld_a=%0d expected 4 and 0", n_cu, n_lda);
    end
  endtask

  task automatic test_mult0101;
    logic [3:0] subs;
    int n_lda, n_sh;
    mult = 8'b0000_0101;
    trace_run(16);
    exp_v[1] = O_INIT;
    for (int i = 0; i < 4; i++) begin
      exp_v[2 + 3 * i] = O_CHECK;
      exp_v[3 + 3 * i] = (i % 2 == 0) ? O_SUB : O_ADD;
      exp_v[4 + 3 * i] = O_SHIFT;
    end
    exp_v[14] = O_CHECK;
    exp_v[15] = O_DONE;
    exp_v[16] = O_IDLE;
    subs = 4'b0;
    n_lda = 0;
    n_sh = 0;
    for (int c = 1; c <= 16; c++) begin
      n_vec++;
      if (tr[c] !== exp_v[c]) begin
        n_err++;
        $display("FAIL mult0101 cyc%0d: outs=%b expected %b", c, tr[c], exp_v[c]);
      end
      if (tr[c][4] === 1'b1) begin
        subs = {subs[2:0], tr[c][3]};
        n_lda++;
      end
      if (tr[c][2] === 1'b1) n_sh++;
    end
    n_vec++;
    if (subs !== 4'b1010 || n_lda != 4 || n_sh != 4) begin
      n_err++;
      $display("FAIL mult0101 ops: sub_seq=%b ld_a=%0d shifts=%0d expected 1010, 4, 4", subs, n_lda, n_sh);
    end
  endtask

  task automatic test_start_ignored;
    mult = 8'd0;
    exp_v[1] = O_INIT;
    for (int i = 0; i < 4; i++) begin
      exp_v[2 + 2 * i] = O_CHECK;
      exp_v[3 + 2 * i] = O_SHIFT;
    end
    exp_v[10] = O_CHECK;
    exp_v[11] = O_DONE;
    exp_v[12] = O_IDLE;
    exp_v[13] = O_INIT;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      n_vec++;
      if (outs !== exp_v[c]) begin
        n_err++;
        $display("FAIL start_ignored cyc%0d: outs=%b expected %b", c, outs, exp_v[c]);
      end
      start = (c == 3) || (c == 11) || (c == 12);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (outs !== O_IDLE) begin
      n_err++;
      $display("FAIL start_ignored rerun_end: outs=%b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_reset_mid_add;
    mult = 8'b0000_0101;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (outs !== O_ADD) begin
      n_err++;
      $display("FAIL abort_at_add: outs=%b expected %b", outs, O_ADD);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs !== O_IDLE) begin
      n_err++;
      $display("FAIL abort_async: outs=%b expected %b", outs, O_IDLE);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        n_err++;
        $display("FAIL abort_hold cyc%0d: done=%b ready=%b expected 0 1", c, done, ready);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    trace_run(16);
    n_vec++;
    if (tr[1] !== O_INIT) begin
      n_err++;
      $display("FAIL abort_rerun_init: outs=%b expected %b", tr[1], O_INIT);
    end
    n_vec++;
    if (tr[15] !== O_DONE || tr[14] !== O_CHECK || tr[16] !== O_IDLE) begin
      n_err++;
      $display("FAIL abort_rerun_done: c14=%b c15=%b c16=%b expected %b %b %b",
               tr[14], tr[15], tr[16], O_CHECK, O_DONE, O_IDLE);
    end
  endtask

  task automatic test_seen4_forced;
    mult = 8'b0000_0101;
    force_s4 = 1'b1;
    trace_run(4);
    force_s4 = 1'b0;
    exp_v[1] = O_INIT;
    exp_v[2] = O_CHECK;
    exp_v[3] = O_DONE;
    exp_v[4] = O_IDLE;
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if (tr[c] !== exp_v[c]) begin
        n_err++;
        $display("FAIL seen4_forced cyc%0d: outs=%b expected %b", c, tr[c], exp_v[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult0();
    test_mult0101();
    test_start_ignored();
    test_reset_mid_add();
    test_seen4_forced();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
